// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle control FSM sequencing one instruction over 3-5 cycles
// Optional bne support when MC_BNE_EN is defined; default build handles beq only.
module mc_control_fsm #(
  parameter int unsigned FETCH_LAT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [2:0] alu_control,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [3:0] LAT = 4'(FETCH_LAT);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_cnt_nxt;
  logic       wb_suppress, wb_suppress_nxt;

  logic [2:0] alu_control_c;
  logic [1:0] alu_src_a_c, alu_src_b_c, result_src_c, imm_src_c;
  logic       adr_src_c, ir_write_c, pc_write_c, reg_write_c, mem_write_c;
  logic       instr_done_c, illegal_c;

  function automatic logic [2:0] alu_map(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_map = sub ? ALU_SUB : ALU_ADD;
      3'b111:  alu_map = ALU_AND;
      3'b110:  alu_map = ALU_OR;
      3'b100:  alu_map = ALU_XOR;
      3'b010:  alu_map = ALU_SLT;
      3'b001:  alu_map = ALU_SLL;
      3'b101:  alu_map = ALU_SRL;
      default: alu_map = ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      wait_cnt    <= 4'd0;
      wb_suppress <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      wb_suppress <= wb_suppress_nxt;
    end
  end

  always_comb begin
    case (opcode)
      OP_SW:   imm_src_c = 2'b01;
      OP_BR:   imm_src_c = 2'b10;
      OP_JAL:  imm_src_c = 2'b11;
      default: imm_src_c = 2'b00;
    endcase
  end

  always_comb begin
    state_nxt       = state;
    wait_cnt_nxt    = wait_cnt;
    wb_suppress_nxt = wb_suppress;
    alu_control_c   = ALU_ADD;
    alu_src_a_c     = 2'b00;
    alu_src_b_c     = 2'b00;
    result_src_c    = 2'b00;
    adr_src_c       = 1'b0;
    ir_write_c      = 1'b0;
    pc_write_c      = 1'b0;
    reg_write_c     = 1'b0;
    mem_write_c     = 1'b0;
    instr_done_c    = 1'b0;
    illegal_c       = 1'b0;

    unique case (state)
      S_FETCH: begin
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        // Hold the fetch address until memory has had FETCH_LAT extra cycles
        if (wait_cnt == LAT) begin
          ir_write_c   = 1'b1;
          pc_write_c   = 1'b1;
          wait_cnt_nxt = 4'd0;
          state_nxt    = S_DECODE;
        end else begin
          wait_cnt_nxt = wait_cnt + 4'd1;
        end
      end
      S_DECODE: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECR;
          OP_I:         state_nxt = S_EXECI;
          OP_BR:        state_nxt = S_BRANCH;
          OP_JAL:       state_nxt = S_JAL;
          default: begin
            illegal_c = 1'b1;
            state_nxt = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        state_nxt   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src_c = 1'b1;
        state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_c    = 1'b1;
        mem_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        alu_src_a_c     = 2'b10;
        alu_src_b_c     = (state == S_EXECI) ? 2'b01 : 2'b00;
        alu_control_c   = alu_map(funct3, (state == S_EXECR) && funct7b5);
        illegal_c       = (funct3 == 3'b011);
        // Remembered so ALUWB can drop the write without looking at funct3 again
        wb_suppress_nxt = (funct3 == 3'b011);
        state_nxt       = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c  = !wb_suppress;
        instr_done_c = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c   = 2'b10;
        alu_control_c = ALU_SUB;
        instr_done_c  = 1'b1;
        state_nxt     = S_FETCH;
        case (funct3)
          3'b000:  pc_write_c = zero;
`ifdef MC_BNE_EN
          3'b001:  pc_write_c = !zero;
`endif
          default: illegal_c  = 1'b1;
        endcase
      end
      S_JAL: begin
        alu_src_a_c     = 2'b01;
        alu_src_b_c     = 2'b10;
        pc_write_c      = 1'b1;
        wb_suppress_nxt = 1'b0;
        state_nxt       = S_ALUWB;
      end
      default: begin
        state_nxt    = S_FETCH;
        wait_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Reset masks every output so nothing pulses while rst_n is low, even before a clock edge
  assign alu_control = rst_n ? alu_control_c : 3'b000;
  assign alu_src_a   = rst_n ? alu_src_a_c   : 2'b00;
  assign alu_src_b   = rst_n ? alu_src_b_c   : 2'b00;
  assign result_src  = rst_n ? result_src_c  : 2'b00;
  assign imm_src     = rst_n ? imm_src_c     : 2'b00;
  assign adr_src     = rst_n & adr_src_c;
  assign ir_write    = rst_n & ir_write_c;
  assign pc_write    = rst_n & pc_write_c;
  assign reg_write   = rst_n & reg_write_c;
  assign mem_write   = rst_n & mem_write_c;
  assign instr_done  = rst_n & instr_done_c;
  assign illegal     = rst_n & illegal_c;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - randomized bench for mc_control_fsm against per-instruction trace model
module tb_mc_control_fsm;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  localparam logic [5:0] EN_IR   = 6'b100000;
  localparam logic [5:0] EN_PC   = 6'b010000;
  localparam logic [5:0] EN_REG  = 6'b001000;
  localparam logic [5:0] EN_MEM  = 6'b000100;
  localparam logic [5:0] EN_DONE = 6'b000010;
  localparam logic [5:0] EN_ILL  = 6'b000001;

  localparam logic [15:0] M_EN  = 16'hFC00;
  localparam logic [15:0] M_ALU = 16'h03F8;
  localparam logic [15:0] M_RS  = 16'h0006;
  localparam logic [15:0] M_AD  = 16'h0001;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
  localparam logic [2:0] XOR_ = 3'b100, SLT = 3'b101, SLL = 3'b110, SRL = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  logic [2:0] alu_control [2];
  logic [1:0] alu_src_a [2];
  logic [1:0] alu_src_b [2];
  logic [1:0] result_src [2];
  logic [1:0] imm_src [2];
  logic       adr_src [2];
  logic       ir_write [2];
  logic       pc_write [2];
  logic       reg_write [2];
  logic       mem_write [2];
  logic       instr_done [2];
  logic       illegal [2];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] val;
    logic [15:0] msk;
  } exp_t;

  exp_t trace[$];

  // funct3 -> ALU op, before the add/sub distinction
  logic [2:0] f3_op [8] = '{ADD, SLL, SLT, ADD, XOR_, SRL, OR_, AND_};

  always #5 clk = ~clk;

  mc_control_fsm #(.FETCH_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .alu_control(alu_control[0]), .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]),
    .result_src(result_src[0]), .imm_src(imm_src[0]), .adr_src(adr_src[0]),
    .ir_write(ir_write[0]), .pc_write(pc_write[0]), .reg_write(reg_write[0]),
    .mem_write(mem_write[0]), .instr_done(instr_done[0]), .illegal(illegal[0])
  );

  mc_control_fsm #(.FETCH_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .alu_control(alu_control[1]), .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]),
    .result_src(result_src[1]), .imm_src(imm_src[1]), .adr_src(adr_src[1]),
    .ir_write(ir_write[1]), .pc_write(pc_write[1]), .reg_write(reg_write[1]),
    .mem_write(mem_write[1]), .instr_done(instr_done[1]), .illegal(illegal[1])
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] observe(input int d);
    return {ir_write[d], pc_write[d], reg_write[d], mem_write[d], instr_done[d], illegal[d],
            alu_control[d], alu_src_a[d], alu_src_b[d], result_src[d], adr_src[d]};
  endfunction

  function automatic exp_t mk(input logic [5:0] en, input logic [2:0] alu, input logic [1:0] a,
                              input logic [1:0] b, input logic [1:0] rs, input logic ad,
                              input logic [15:0] extra);
    exp_t e;
    e.val = {en, alu, a, b, rs, ad};
    e.msk = M_EN | extra;
    return e;
  endfunction

  function automatic logic [1:0] imm_model(input logic [6:0] op);
    if (op == OP_SW)  return 2'b01;
    if (op == OP_BR)  return 2'b10;
    if (op == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  // Expected cycle-by-cycle outputs of one whole instruction, FETCH through its last cycle
  function automatic void build_trace(input int lat, input logic [6:0] op, input logic [2:0] f3,
                                      input logic f7, input logic z);
    logic       legal, bad, take, ill;
    logic [2:0] alu;
    trace.delete();
    for (int k = 0; k <= lat; k++)
      trace.push_back(mk((k == lat) ? (EN_IR | EN_PC) : 6'b0, ADD, 2'b00, 2'b10, 2'b10, 1'b0,
                         M_ALU | M_RS | M_AD));
    legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_I) ||
            (op == OP_BR) || (op == OP_JAL);
    trace.push_back(mk(legal ? 6'b0 : EN_ILL, ADD, 2'b01, 2'b01, 2'b00, 1'b0, M_ALU));
    if (op == OP_LW || op == OP_SW)
      trace.push_back(mk(6'b0, ADD, 2'b10, 2'b01, 2'b00, 1'b0, M_ALU));
    if (op == OP_LW) begin
      trace.push_back(mk(6'b0, ADD, 2'b00, 2'b00, 2'b00, 1'b1, M_RS | M_AD));
      trace.push_back(mk(EN_REG | EN_DONE, ADD, 2'b00, 2'b00, 2'b01, 1'b0, M_RS));
    end else if (op == OP_SW) begin
      trace.push_back(mk(EN_MEM | EN_DONE, ADD, 2'b00, 2'b00, 2'b00, 1'b1, M_RS | M_AD));
    end else if (op == OP_R || op == OP_I) begin
      bad = (f3 == 3'b011);
      alu = (f3 == 3'b000 && op == OP_R && f7) ? SUB : f3_op[f3];
      trace.push_back(mk(bad ? EN_ILL : 6'b0, alu, 2'b10, (op == OP_I) ? 2'b01 : 2'b00, 2'b00,
                         1'b0, M_ALU));
      trace.push_back(mk((bad ? 6'b0 : EN_REG) | EN_DONE, ADD, 2'b00, 2'b00, 2'b00, 1'b0, M_RS));
    end else if (op == OP_BR) begin
      take = (f3 == 3'b000) && z;
      ill  = (f3 != 3'b000);
`ifdef MC_BNE_EN
      if (f3 == 3'b001) begin
        take = !z;
        ill  = 1'b0;
      end
`endif
      trace.push_back(mk((take ? EN_PC : 6'b0) | (ill ? EN_ILL : 6'b0) | EN_DONE, SUB, 2'b10,
                         2'b00, 2'b00, 1'b0, M_ALU | M_RS));
    end else if (op == OP_JAL) begin
      trace.push_back(mk(EN_PC, ADD, 2'b01, 2'b10, 2'b00, 1'b0, M_ALU | M_RS));
      trace.push_back(mk(EN_REG | EN_DONE, ADD, 2'b00, 2'b00, 2'b00, 1'b0, M_RS));
    end
  endfunction

  // Called #1 after a rising edge with the DUT at the first FETCH cycle
  task automatic run_instr(input int d, input string name, input logic [6:0] op,
                           input logic [2:0] f3, input logic f7, input logic z, input int abort_at);
    build_trace((d == 1) ? 3 : 0, op, f3, f7, z);
    opcode   = op;
    funct3   = f3;
    funct7b5 = f7;
    zero     = z;
    for (int i = 0; i < trace.size(); i++) begin
      @(negedge clk);
      chk($sformatf("%s_c%0d", name, i + 1), observe(d) & trace[i].msk, trace[i].val & trace[i].msk);
      if (i == 0) chk($sformatf("%s_imm", name), {14'b0, imm_src[d]}, {14'b0, imm_model(op)});
      if (i == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk($sformatf("%s_async_rst", name), observe(d), 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int d);
    rst_n  = 1'b0;
    opcode = OP_JAL;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", observe(d), 16'h0000);
    chk("reset_imm", {14'b0, imm_src[d]}, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_random(input int d, input int count);
    logic [6:0] ops [7] = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_BAD};
    logic [6:0] op;
    for (int n = 0; n < count; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 6)];
      run_instr(d, $sformatf("rnd%0d_%0d_op%b", d, n, op), op, 3'($urandom), 1'($urandom),
                1'($urandom), -1);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    opcode   = OP_JAL;
    funct3   = 3'b000;
    funct7b5 = 1'b0;
    zero     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("por_outputs0", observe(0), 16'h0000);
    chk("por_outputs3", observe(1), 16'h0000);
    chk("por_imm", {14'b0, imm_src[0]}, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_instr(0, "add",      OP_R,   3'b000, 1'b0, 1'b0, -1);
    run_instr(0, "sub",      OP_R,   3'b000, 1'b1, 1'b0, -1);
    run_instr(0, "lw",       OP_LW,  3'b010, 1'b0, 1'b0, -1);
    run_instr(0, "sw",       OP_SW,  3'b010, 1'b0, 1'b0, -1);
    run_instr(0, "beq_z1",   OP_BR,  3'b000, 1'b0, 1'b1, -1);
    run_instr(0, "beq_z0",   OP_BR,  3'b000, 1'b0, 1'b0, -1);
    run_instr(0, "bne_z1",   OP_BR,  3'b001, 1'b0, 1'b1, -1);
    run_instr(0, "bne_z0",   OP_BR,  3'b001, 1'b0, 1'b0, -1);
    run_instr(0, "jal",      OP_JAL, 3'b101, 1'b1, 1'b0, -1);
    run_instr(0, "illegal",  OP_BAD, 3'b000, 1'b0, 1'b0, -1);
    run_instr(0, "addi_f7",  OP_I,   3'b000, 1'b1, 1'b0, -1);
    run_instr(0, "r_f3_011", OP_R,   3'b011, 1'b0, 1'b0, -1);
    run_instr(0, "i_f3_011", OP_I,   3'b011, 1'b0, 1'b0, -1);
    run_instr(0, "jal_after", OP_JAL, 3'b011, 1'b0, 1'b0, -1);
    run_instr(0, "srl",      OP_R,   3'b101, 1'b1, 1'b0, -1);
    run_random(0, 60);

    run_instr(0, "sw_abort", OP_SW,  3'b010, 1'b0, 1'b0, 3);
    run_instr(0, "add_post", OP_R,   3'b111, 1'b0, 1'b0, -1);

    do_reset(1);
    run_instr(1, "lat3_add", OP_R,   3'b000, 1'b0, 1'b0, -1);
    run_instr(1, "lat3_bad", OP_BAD, 3'b000, 1'b0, 1'b0, -1);
    run_random(1, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
